// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle add/subtract unit that reuses one 4-bit carry-lookahead
// adder, one nibble per clock LSB first, with the carry held in a register.

module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);
  assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;
endmodule

module cla_nibble_seq_adder #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BW = IW + 2;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [BW-1:0]    base;
  logic [3:0]       cla_a;
  logic [3:0]       cla_b;
  logic [3:0]       cla_s;
  logic             cla_co;

  // Operands stay intact; the active nibble is picked by idx.
  assign base  = {idx_q, 2'b00};
  assign cla_a = opa_q[base +: 4];
  assign cla_b = opb_q[base +: 4];

  cla4 u_cla (
    .a_i (cla_a),
    .b_i (cla_b),
    .c_i (carry_q),
    .s_o (cla_s),
    .c_o (cla_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: 4] = cla_s;
        carry_d = cla_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
          cout_d  = cla_co;
          ovf_d   = (opa_q[WIDTH-1] ~^ opb_q[WIDTH-1])
                  & (cla_s[3] ^ opa_q[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = cout_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Testbench for cla_nibble_seq_adder: directed, random, ignore-start,
// back-to-back and mid-run reset scenarios against an arithmetic model.

module tb_cla_nibble_seq_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  logic last_cout = 1'b0;
  logic last_ovf  = 1'b0;

  cla_nibble_seq_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // {c_out, ovf, sum} from plain integer arithmetic
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic s);
    int ux, uy, sx, sy, ures, sres;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ures = ux - uy;
      co   = (ux >= uy);
      sres = sx - sy;
    end else begin
      ures = ux + uy;
      co   = (ures > 65535);
      sres = sx + sy;
    end
    ov = (sres > 32767) || (sres < -32768);
    return {co, ov, ures[W-1:0]};
  endfunction

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s);
    @(negedge clk);
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, c_out, ovf} !== 4'b0 || sum !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b sum=%h c=%b o=%b want 0",
               busy, done, sum, c_out, ovf);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || sum !== '0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b sum=%h want 0 0 0",
               busy, done, sum);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005};
    logic [W-1:0] tb [5] = '{16'h0FCD, 16'h0001, 16'h0001, 16'h0001, 16'h0007};
    logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] exp;
    for (int v = 0; v < 5; v++) begin
      exp = ref_op(ta[v], tb[v], ts[v]);
      issue(ta[v], tb[v], ts[v]);
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 ||
            c_out !== last_cout || ovf !== last_ovf) begin
          errors++;
          $display("FAIL dir%0d_run%0d busy=%b done=%b c=%b o=%b want 1 0 %b %b",
                   v, i, busy, done, c_out, ovf, last_cout, last_ovf);
        end
        if (i == 0) begin
          checks++;
          if (sum !== '0) begin
            errors++;
            $display("FAIL dir%0d_sum_clear sum=%h want 0000", v, sum);
          end
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || sum !== exp[W-1:0] ||
          c_out !== exp[W+1] || ovf !== exp[W]) begin
        errors++;
        $display("FAIL dir%0d_done done=%b busy=%b sum=%h c=%b o=%b want 1 0 %h %b %b",
                 v, done, busy, sum, c_out, ovf, exp[W-1:0], exp[W+1], exp[W]);
      end
      last_cout = exp[W+1];
      last_ovf  = exp[W];
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== exp[W-1:0] ||
          c_out !== exp[W+1] || ovf !== exp[W]) begin
        errors++;
        $display("FAIL dir%0d_hold done=%b busy=%b sum=%h c=%b o=%b want 0 0 %h %b %b",
                 v, done, busy, sum, c_out, ovf, exp[W-1:0], exp[W+1], exp[W]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic s;
    logic [W+1:0] exp;
    int n;
    for (int v = 0; v < 25; v++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      s = 1'($urandom);
      exp = ref_op(x, y, s);
      issue(x, y, s);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done !== 1'b1 && n < 20);
      checks++;
      if (n != N + 1 || sum !== exp[W-1:0] ||
          c_out !== exp[W+1] || ovf !== exp[W]) begin
        errors++;
        $display("FAIL rnd%0d %h%s%h lat=%0d sum=%h c=%b o=%b want lat=%0d %h %b %b",
                 v, x, s ? "-" : "+", y, n, sum, c_out, ovf,
                 N + 1, exp[W-1:0], exp[W+1], exp[W]);
      end
      last_cout = exp[W+1];
      last_ovf  = exp[W];
    end
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] exp;
    logic [W-1:0] got;
    int ndone = 0;
    int first = -1;
    exp = ref_op(16'h0005, 16'h0007, 1'b1);
    issue(16'h0005, 16'h0007, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    a = 16'h0001;
    b = 16'h0001;
    sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = i;
        got = sum;
      end
    end
    checks++;
    if (ndone != 1 || first != 2 || got !== exp[W-1:0] ||
        c_out !== exp[W+1] || ovf !== exp[W]) begin
      errors++;
      $display("FAIL ignore_start dones=%0d at=%0d sum=%h c=%b o=%b want 1 2 %h %b %b",
               ndone, first, got, c_out, ovf, exp[W-1:0], exp[W+1], exp[W]);
    end
    last_cout = exp[W+1];
    last_ovf  = exp[W];
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] e1, e2;
    int n;
    e1 = ref_op(16'hF000, 16'h1000, 1'b0);
    e2 = ref_op(16'h0010, 16'h0020, 1'b0);
    issue(16'hF000, 16'h1000, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
    checks++;
    if (n != N + 1 || sum !== e1[W-1:0] || c_out !== e1[W+1]) begin
      errors++;
      $display("FAIL b2b_first lat=%0d sum=%h c=%b want %0d %h %b",
               n, sum, c_out, N + 1, e1[W-1:0], e1[W+1]);
    end
    start = 1'b1;
    a = 16'h0010;
    b = 16'h0020;
    sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== '0 ||
            c_out !== e1[W+1]) begin
          errors++;
          $display("FAIL b2b_no_idle busy=%b done=%b sum=%h c=%b want 1 0 0000 %b",
                   busy, done, sum, c_out, e1[W+1]);
        end
      end
    end while (done !== 1'b1 && n < 20);
    checks++;
    if (n != N + 1 || sum !== e2[W-1:0] ||
        c_out !== e2[W+1] || ovf !== e2[W]) begin
      errors++;
      $display("FAIL b2b_second lat=%0d sum=%h c=%b o=%b want %0d %h %b %b",
               n, sum, c_out, ovf, N + 1, e2[W-1:0], e2[W+1], e2[W]);
    end
    last_cout = e2[W+1];
    last_ovf  = e2[W];
  endtask

  task automatic test_reset_mid_run();
    logic [W+1:0] exp;
    int n;
    int ndone = 0;
    exp = ref_op(16'h1111, 16'h2222, 1'b0);
    issue(16'h1111, 16'h2222, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, c_out, ovf} !== 4'b0 || sum !== '0) begin
      errors++;
      $display("FAIL midrun_reset busy=%b done=%b sum=%h c=%b o=%b want 0",
               busy, done, sum, c_out, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || sum !== '0) begin
      errors++;
      $display("FAIL midrun_no_done active=%0d sum=%h want 0 0000", ndone, sum);
    end
    issue(16'h1111, 16'h2222, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
    checks++;
    if (n != N + 1 || sum !== exp[W-1:0] ||
        c_out !== exp[W+1] || ovf !== exp[W]) begin
      errors++;
      $display("FAIL midrun_recover lat=%0d sum=%h c=%b o=%b want %0d %h %b %b",
               n, sum, c_out, ovf, N + 1, exp[W-1:0], exp[W+1], exp[W]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
